// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time system ID checker: reads the sysid slave's ID and build timestamp,
// compares them against the image's expected values and retries on mismatch.
module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1453302424,
  parameter int          READ_LATENCY       = 0,
  parameter int          MAX_RETRIES        = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        timestamp_ok,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic [2:0]  attempts,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ID   = 2'd1,
    RD_TS   = 2'd2,
    COMPARE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  lat_cnt;
  logic [2:0]  retry_cnt;
  logic        lat_last;
  logic        id_match;
  logic        ts_match;
  logic        accept;
  logic        publish;
  logic        retry;
  logic        read_n;
  logic        addr_n;

  assign lat_last  = (lat_cnt == 2'(READ_LATENCY));
  assign id_match  = (id_value == EXPECTED_ID);
  assign ts_match  = (timestamp_value == EXPECTED_TIMESTAMP);
  assign fsm_state = state;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RD_ID;
      RD_ID:   if (lat_last) state_n = RD_TS;
      RD_TS:   if (lat_last) state_n = COMPARE;
      COMPARE: begin
        if (!(id_match && ts_match) && (retry_cnt < 3'(MAX_RETRIES))) state_n = RD_ID;
        else                                                          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Slave handshake: address/read are held constant for READ_LATENCY+1 cycles
  // and sysid_readdata is sampled on the last edge; no ready/wait signal exists.
  always_comb begin
    accept  = (state == IDLE) && start;
    publish = (state == COMPARE) && (state_n == IDLE);
    retry   = (state == COMPARE) && (state_n == RD_ID);
    read_n  = (state_n == RD_ID) || (state_n == RD_TS);
    addr_n  = (state_n == RD_TS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sysid_read      <= 1'b0;
      sysid_address   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      id_ok           <= 1'b0;
      timestamp_ok    <= 1'b0;
      pass            <= 1'b0;
      id_value        <= 32'd0;
      timestamp_value <= 32'd0;
      attempts        <= 3'd0;
      lat_cnt         <= 2'd0;
      retry_cnt       <= 3'd0;
    end else begin
      sysid_read    <= read_n;
      sysid_address <= addr_n;
      busy          <= (state_n != IDLE);
      done          <= publish;

      if ((state == RD_ID) || (state == RD_TS)) lat_cnt <= lat_last ? 2'd0 : lat_cnt + 2'd1;
      else                                      lat_cnt <= 2'd0;

      if ((state == RD_ID) && lat_last) id_value        <= sysid_readdata;
      if ((state == RD_TS) && lat_last) timestamp_value <= sysid_readdata;

      if (accept) begin
        id_ok        <= 1'b0;
        timestamp_ok <= 1'b0;
        pass         <= 1'b0;
        attempts     <= 3'd1;
        retry_cnt    <= 3'd0;
      end else if (retry) begin
        // Eight attempts (MAX_RETRIES=7) wrap attempts to 3'd0 by design.
        attempts  <= attempts + 3'd1;
        retry_cnt <= retry_cnt + 3'd1;
      end

      if (publish) begin
        id_ok        <= id_match;
        timestamp_ok <= ts_match;
        pass         <= id_match && ts_match;
      end
    end
  end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Self-checking bench: table of slave-data scenarios plus hand-written
// sequences for retry, re-start, reset and latency/retry-limit variants.
module tb_first_nios2_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1453302424;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: defaults (L=0, MAX_RETRIES=2)
  logic        start_a = 1'b0;
  logic [31:0] id_a = 32'd0, ts_a = 32'd0;
  logic        addr_a, read_a, busy_a, done_a, idok_a, tsok_a, pass_a;
  logic [31:0] rd_a, idv_a, tsv_a;
  logic [2:0]  att_a;
  logic [1:0]  st_a;
  assign rd_a = addr_a ? ts_a : id_a;

  first_nios2_system_sysid_checker dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .sysid_address(addr_a), .sysid_read(read_a), .sysid_readdata(rd_a),
    .busy(busy_a), .done(done_a), .id_ok(idok_a), .timestamp_ok(tsok_a),
    .pass(pass_a), .id_value(idv_a), .timestamp_value(tsv_a),
    .attempts(att_a), .fsm_state(st_a)
  );

  // Instance B: L=2, slave data pipelined two cycles behind the address
  logic        start_b = 1'b0;
  logic [31:0] d1_b = 32'd0, d2_b = 32'd0;
  logic        addr_b, read_b, busy_b, done_b, idok_b, tsok_b, pass_b;
  logic [31:0] idv_b, tsv_b;
  logic [2:0]  att_b;
  logic [1:0]  st_b;
  always @(posedge clock) begin
    d1_b <= addr_b ? EXP_TS : EXP_ID;
    d2_b <= d1_b;
  end

  first_nios2_system_sysid_checker #(.READ_LATENCY(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .sysid_address(addr_b), .sysid_read(read_b), .sysid_readdata(d2_b),
    .busy(busy_b), .done(done_b), .id_ok(idok_b), .timestamp_ok(tsok_b),
    .pass(pass_b), .id_value(idv_b), .timestamp_value(tsv_b),
    .attempts(att_b), .fsm_state(st_b)
  );

  // Instance C: MAX_RETRIES=7, slave always returns a wrong timestamp
  logic        start_c = 1'b0;
  logic        addr_c, read_c, busy_c, done_c, idok_c, tsok_c, pass_c;
  logic [31:0] rd_c, idv_c, tsv_c;
  logic [2:0]  att_c;
  logic [1:0]  st_c;
  assign rd_c = addr_c ? 32'h1234_5678 : EXP_ID;

  first_nios2_system_sysid_checker #(.MAX_RETRIES(7)) dut_c (
    .clock(clock), .reset(reset), .start(start_c),
    .sysid_address(addr_c), .sysid_read(read_c), .sysid_readdata(rd_c),
    .busy(busy_c), .done(done_c), .id_ok(idok_c), .timestamp_ok(tsok_c),
    .pass(pass_c), .id_value(idv_c), .timestamp_value(tsv_c),
    .attempts(att_c), .fsm_state(st_c)
  );

  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          done_cycle;
    logic        exp_pass;
    logic        exp_id_ok;
    logic        exp_ts_ok;
    logic [2:0]  exp_attempts;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulses start on A (cycle 0) and returns the cycle index where done is seen.
  task automatic run_a(output int done_at, output int busy_bad);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    done_at = 1;
    busy_bad = 0;
    while (!done_a && done_at < 60) begin
      if (!busy_a) busy_bad++;
      tick();
      done_at++;
    end
  endtask

  int done_at, busy_bad, seen;

  initial begin
    vecs[0] = '{EXP_ID,        EXP_TS,         4, 1'b1, 1'b1, 1'b1, 3'd1};
    vecs[1] = '{EXP_ID,        EXP_TS + 32'd1, 10, 1'b0, 1'b1, 1'b0, 3'd3};
    vecs[2] = '{32'hDEADBEEF,  EXP_TS,         10, 1'b0, 1'b0, 1'b1, 3'd3};
    vecs[3] = '{32'd1,         32'd0,          10, 1'b0, 1'b0, 1'b0, 3'd3};
    vecs[4] = '{32'h8000_0000, EXP_TS ^ 32'h8000_0000, 10, 1'b0, 1'b0, 1'b0, 3'd3};

    tick(); tick();
    reset = 1'b0;
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_read", {31'd0, read_a}, 32'd0);
    check("reset_pass", {31'd0, pass_a}, 32'd0);
    check("reset_attempts", {29'd0, att_a}, 32'd0);
    check("reset_id_value", idv_a, 32'd0);

    // Table-driven scenarios on instance A
    for (int i = 0; i < 5; i++) begin
      id_a = vecs[i].id_word;
      ts_a = vecs[i].ts_word;
      run_a(done_at, busy_bad);
      check($sformatf("v%0d_done_cycle", i), done_at, vecs[i].done_cycle);
      check($sformatf("v%0d_busy_during", i), busy_bad, 0);
      check($sformatf("v%0d_busy_at_done", i), {31'd0, busy_a}, 32'd0);
      check($sformatf("v%0d_pass", i), {31'd0, pass_a}, {31'd0, vecs[i].exp_pass});
      check($sformatf("v%0d_id_ok", i), {31'd0, idok_a}, {31'd0, vecs[i].exp_id_ok});
      check($sformatf("v%0d_ts_ok", i), {31'd0, tsok_a}, {31'd0, vecs[i].exp_ts_ok});
      check($sformatf("v%0d_attempts", i), {29'd0, att_a}, {29'd0, vecs[i].exp_attempts});
      check($sformatf("v%0d_id_value", i), idv_a, vecs[i].id_word);
      check($sformatf("v%0d_ts_value", i), tsv_a, vecs[i].ts_word);
      tick();
      check($sformatf("v%0d_done_pulse", i), {31'd0, done_a}, 32'd0);
      tick();
    end

    // Read sequencing at L=0: address 0 in cycle 1, address 1 in cycle 2
    id_a = EXP_ID; ts_a = EXP_TS;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("seq_c1_read", {31'd0, read_a}, 32'd1);
    check("seq_c1_addr", {31'd0, addr_a}, 32'd0);
    tick();
    check("seq_c2_read", {31'd0, read_a}, 32'd1);
    check("seq_c2_addr", {31'd0, addr_a}, 32'd1);
    tick();
    check("seq_c3_read", {31'd0, read_a}, 32'd0);
    check("seq_c3_busy", {31'd0, busy_a}, 32'd1);
    tick();
    check("seq_c4_done", {31'd0, done_a}, 32'd1);
    tick(); tick();

    // Wrong ID on the first pass only
    id_a = 32'hDEADBEEF;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    id_a = EXP_ID;
    done_at = 2;
    while (!done_a && done_at < 60) begin tick(); done_at++; end
    check("retry_done_cycle", done_at, 7);
    check("retry_pass", {31'd0, pass_a}, 32'd1);
    check("retry_attempts", {29'd0, att_a}, 32'd2);
    tick(); tick();

    // Start while busy is ignored; start in the done cycle is accepted
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("busy_restart_c3_done", {31'd0, done_a}, 32'd0);
    tick();
    check("busy_restart_c4_done", {31'd0, done_a}, 32'd1);
    check("busy_restart_c4_pass", {31'd0, pass_a}, 32'd1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("done_restart_c5_pass", {31'd0, pass_a}, 32'd0);
    check("done_restart_c5_busy", {31'd0, busy_a}, 32'd1);
    check("done_restart_c5_done", {31'd0, done_a}, 32'd0);
    tick(); tick(); tick();
    check("done_restart_c8_done", {31'd0, done_a}, 32'd1);
    check("done_restart_c8_pass", {31'd0, pass_a}, 32'd1);
    tick(); tick();

    // Synchronous reset mid-check
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    check("rst_mid_read", {31'd0, read_a}, 32'd0);
    check("rst_mid_pass", {31'd0, pass_a}, 32'd0);
    check("rst_mid_attempts", {29'd0, att_a}, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_a) seen++;
      tick();
    end
    check("rst_mid_no_done", seen, 0);
    run_a(done_at, busy_bad);
    check("rst_after_done_cycle", done_at, 4);
    check("rst_after_pass", {31'd0, pass_a}, 32'd1);
    tick(); tick();

    // Instance B: READ_LATENCY=2
    start_b = 1'b1; tick(); start_b = 1'b0;
    seen = 0;
    for (int c = 1; c <= 3; c++) begin
      if (read_b && !addr_b) seen++;
      tick();
    end
    for (int c = 4; c <= 6; c++) begin
      if (read_b && addr_b) seen++;
      tick();
    end
    check("lat2_read_cycles", seen, 6);
    check("lat2_c7_read", {31'd0, read_b}, 32'd0);
    check("lat2_c7_done", {31'd0, done_b}, 32'd0);
    tick();
    check("lat2_c8_done", {31'd0, done_b}, 32'd1);
    check("lat2_pass", {31'd0, pass_b}, 32'd1);
    check("lat2_id_value", idv_b, EXP_ID);
    check("lat2_ts_value", tsv_b, EXP_TS);
    tick(); tick();

    // Instance C: eight passes, attempts encoded as 3'd0
    start_c = 1'b1; tick(); start_c = 1'b0;
    done_at = 1;
    while (!done_c && done_at < 60) begin tick(); done_at++; end
    check("max7_done_cycle", done_at, 25);
    check("max7_attempts", {29'd0, att_c}, 32'd0);
    check("max7_pass", {31'd0, pass_c}, 32'd0);
    check("max7_id_ok", {31'd0, idok_c}, 32'd1);
    check("max7_ts_ok", {31'd0, tsok_c}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
